// File: rtl/proc_control_unit.sv
// Control FSM for the 9-bit simple processor: holds IR and sequences
// mv/mvi/add/sub over T0..T3 by driving bus-source selects and load enables.
module proc_control_unit #(
    parameter int unsigned WIDTH = 9
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Run,
    input  logic [WIDTH-1:0] Din,
    output logic [9:0]       bus_sel,
    output logic [7:0]       Rin,
    output logic             IRin,
    output logic             Ain,
    output logic             Gin,
    output logic             AddSub,
    output logic             Done,
    output logic [1:0]       step,
    output logic [WIDTH-1:0] ir
);

    localparam int unsigned SEL_W = 10;
    localparam int unsigned REG_N = 8;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    localparam logic [SEL_W-1:0] SEL_GOUT   = SEL_W'(2);
    localparam logic [SEL_W-1:0] SEL_DINOUT = SEL_W'(1);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] ir_q, ir_d;

    logic [2:0] op, rx, ry;
    logic       is_addsub;

    assign op        = ir_q[8:6];
    assign rx        = ir_q[5:3];
    assign ry        = ir_q[2:0];
    assign is_addsub = (op == OP_ADD) || (op == OP_SUB);

    // R0out sits in the MSB of bus_sel, R7out just above Gout.
    function automatic logic [SEL_W-1:0] r_out(input logic [2:0] idx);
        return SEL_W'(10'b10_0000_0000) >> idx;
    endfunction

    function automatic logic [REG_N-1:0] r_in(input logic [2:0] idx);
        return REG_N'(1) << idx;
    endfunction

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= T0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        bus_sel = '0;
        Rin     = '0;
        IRin    = 1'b0;
        Ain     = 1'b0;
        Gin     = 1'b0;
        AddSub  = 1'b0;
        Done    = 1'b0;
        step    = state_q;
        ir      = ir_q;

        case (state_q)
            T0: begin
                IRin = Run;
                if (Run) begin
                    ir_d    = Din;
                    state_d = T1;
                end
            end
            T1: begin
                case (op)
                    OP_MV: begin
                        bus_sel = r_out(ry);
                        Rin     = r_in(rx);
                        Done    = 1'b1;
                        state_d = T0;
                    end
                    OP_MVI: begin
                        bus_sel = SEL_DINOUT;
                        Rin     = r_in(rx);
                        Done    = 1'b1;
                        state_d = T0;
                    end
                    OP_ADD, OP_SUB: begin
                        bus_sel = r_out(rx);
                        Ain     = 1'b1;
                        state_d = T2;
                    end
                    default: begin
                        Done    = 1'b1;
                        state_d = T0;
                    end
                endcase
            end
            T2: begin
                state_d = T0;
                if (is_addsub) begin
                    bus_sel = r_out(ry);
                    Gin     = 1'b1;
                    AddSub  = op[0];
                    state_d = T3;
                end
            end
            T3: begin
                state_d = T0;
                if (is_addsub) begin
                    bus_sel = SEL_GOUT;
                    Rin     = r_in(rx);
                    Done    = 1'b1;
                end
            end
            default: begin
                step    = 2'd0;
                state_d = T0;
            end
        endcase

        // Reset cycle silences every output, aborting any instruction in flight.
        if (Reset) begin
            bus_sel = '0;
            Rin     = '0;
            IRin    = 1'b0;
            Ain     = 1'b0;
            Gin     = 1'b0;
            AddSub  = 1'b0;
            Done    = 1'b0;
            step    = 2'd0;
            ir      = '0;
        end
    end

endmodule

// File: tb/tb_proc_control_unit.sv
// Bench for proc_control_unit: a small datapath executes the control outputs
// and its register file is compared against an instruction-level model.
module tb_proc_control_unit;

    logic       Clock;
    logic       Reset;
    logic       Run;
    logic [8:0] Din;
    logic [9:0] bus_sel;
    logic [7:0] Rin;
    logic       IRin, Ain, Gin, AddSub, Done;
    logic [1:0] step;
    logic [8:0] ir;

    int total = 0;
    int bad   = 0;

    proc_control_unit #(.WIDTH(9)) dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .Run    (Run),
        .Din    (Din),
        .bus_sel(bus_sel),
        .Rin    (Rin),
        .IRin   (IRin),
        .Ain    (Ain),
        .Gin    (Gin),
        .AddSub (AddSub),
        .Done   (Done),
        .step   (step),
        .ir     (ir)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Datapath driven purely by the DUT's control outputs.
    logic       dp_clear;
    logic [8:0] dp_r [8];
    logic [8:0] dp_a, dp_g, bus;

    always_comb begin
        bus = '0;
        for (int i = 0; i < 8; i++)
            if (bus_sel[9-i]) bus = bus | dp_r[i];
        if (bus_sel[1]) bus = bus | dp_g;
        if (bus_sel[0]) bus = bus | Din;
    end

    always @(posedge Clock) begin
        if (dp_clear) begin
            for (int i = 0; i < 8; i++) dp_r[i] <= '0;
            dp_a <= '0;
            dp_g <= '0;
        end else begin
            for (int i = 0; i < 8; i++)
                if (Rin[i]) dp_r[i] <= bus;
            if (Ain) dp_a <= bus;
            if (Gin) dp_g <= AddSub ? (dp_a - bus) : (dp_a + bus);
        end
    end

    // Instruction-level model of the register file.
    logic [8:0] mdl [8];

    task automatic model_apply(input logic [8:0] instr, input logic [8:0] imm);
        logic [2:0] o, x, y;
        o = instr[8:6];
        x = instr[5:3];
        y = instr[2:0];
        case (o)
            3'b000: mdl[x] = mdl[y];
            3'b001: mdl[x] = imm;
            3'b010: mdl[x] = mdl[x] + mdl[y];
            3'b011: mdl[x] = mdl[x] - mdl[y];
            default: ;
        endcase
    endtask

    function automatic logic [71:0] pack_dp();
        logic [71:0] p;
        for (int i = 0; i < 8; i++) p[i*9 +: 9] = dp_r[i];
        return p;
    endfunction

    function automatic logic [71:0] pack_mdl();
        logic [71:0] p;
        for (int i = 0; i < 8; i++) p[i*9 +: 9] = mdl[i];
        return p;
    endfunction

    task automatic chk(input string tag, input logic [79:0] observed, input logic [79:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_bus"},  80'(bus_sel), 80'(0));
        chk({tag, "_rin"},  80'(Rin), 80'(0));
        chk({tag, "_done"}, 80'(Done), 80'(0));
    endtask

    // Issue one instruction from T0 and follow it until Done.
    task automatic exec(input logic [8:0] instr, input logic [8:0] imm);
        int n;
        int exp_lat;
        Run = 1'b1;
        Din = instr;
        #1;
        chk("t0_irin", 80'(IRin), 80'(1));
        chk("t0_step", 80'(step), 80'(0));
        tick();
        Run = 1'($urandom);
        Din = imm;
        #1;
        chk("t1_ir", 80'(ir), 80'(instr));
        n = 1;
        while (Done !== 1'b1 && n < 6) begin
            chk("onehot", 80'($countones(bus_sel) <= 1), 80'(1));
            tick();
            Run = 1'($urandom);
            Din = 9'($urandom);
            #1;
            n++;
        end
        exp_lat = (instr[8:7] == 2'b01) ? 3 : 1;
        chk("latency", 80'(n), 80'(exp_lat));
        tick();
        Run = 1'b0;
        #1;
        chk("after_step", 80'(step), 80'(0));
        model_apply(instr, imm);
        chk("regfile", 80'(pack_dp()), 80'(pack_mdl()));
    endtask

    initial begin
        Reset    = 1'b1;
        Run      = 1'b0;
        Din      = '0;
        dp_clear = 1'b1;
        for (int i = 0; i < 8; i++) mdl[i] = '0;

        // Reset held: every output forced low, even with Run asserted.
        tick();
        Run = 1'b1;
        #1;
        chk("rst_irin", 80'(IRin), 80'(0));
        chk_quiet("rst");
        chk("rst_ir", 80'(ir), 80'(0));
        tick();
        Reset    = 1'b0;
        Run      = 1'b0;
        dp_clear = 1'b0;
        #1;

        // Idle with Run low stays in T0.
        for (int c = 0; c < 5; c++) begin
            chk("idle_step", 80'(step), 80'(0));
            chk_quiet("idle");
            tick();
        end

        // mvi R2,#5
        Run = 1'b1;
        Din = 9'b001_010_000;
        tick();
        Run = 1'b0;
        Din = 9'h005;
        #1;
        chk("mvi_bus",  80'(bus_sel), 80'(10'b0000000001));
        chk("mvi_rin",  80'(Rin), 80'(8'b00000100));
        chk("mvi_done", 80'(Done), 80'(1));
        tick();
        chk("mvi_step", 80'(step), 80'(0));
        model_apply(9'b001_010_000, 9'h005);
        chk("mvi_reg", 80'(pack_dp()), 80'(pack_mdl()));

        // Load distinct random values into every register.
        for (int i = 0; i < 8; i++)
            exec({3'b001, 3'(i), 3'b000}, 9'($urandom));

        // mv R1,R6
        Run = 1'b1;
        Din = 9'b000_001_110;
        tick();
        Run = 1'b0;
        #1;
        chk("mv_bus",  80'(bus_sel), 80'(10'b0000001000));
        chk("mv_rin",  80'(Rin), 80'(8'b00000010));
        chk("mv_done", 80'(Done), 80'(1));
        tick();
        model_apply(9'b000_001_110, 9'h000);
        chk("mv_reg", 80'(pack_dp()), 80'(pack_mdl()));

        // sub R3,R5 through T1..T3
        Run = 1'b1;
        Din = 9'b011_011_101;
        tick();
        Run = 1'b0;
        #1;
        chk("sub_t1_bus",  80'(bus_sel), 80'(10'b0001000000));
        chk("sub_t1_ain",  80'(Ain), 80'(1));
        chk("sub_t1_done", 80'(Done), 80'(0));
        tick();
        chk("sub_t2_step", 80'(step), 80'(2));
        chk("sub_t2_bus",  80'(bus_sel), 80'(10'b0000010000));
        chk("sub_t2_gin",  80'(Gin), 80'(1));
        chk("sub_t2_as",   80'(AddSub), 80'(1));
        tick();
        chk("sub_t3_bus",  80'(bus_sel), 80'(10'b0000000010));
        chk("sub_t3_rin",  80'(Rin), 80'(8'b00001000));
        chk("sub_t3_done", 80'(Done), 80'(1));
        tick();
        chk("sub_step", 80'(step), 80'(0));
        model_apply(9'b011_011_101, 9'h000);
        chk("sub_reg", 80'(pack_dp()), 80'(pack_mdl()));

        // add R0,R7 aborted by Reset in T2
        Run = 1'b1;
        Din = 9'b010_000_111;
        tick();
        Run = 1'b0;
        tick();
        Reset = 1'b1;
        #1;
        chk("abort_gin",  80'(Gin), 80'(0));
        chk("abort_step", 80'(step), 80'(0));
        chk_quiet("abort");
        tick();
        Reset = 1'b0;
        #1;
        chk("abort_t0", 80'(step), 80'(0));
        chk("abort_ir", 80'(ir), 80'(0));
        for (int c = 0; c < 3; c++) begin
            chk_quiet("post_abort");
            tick();
        end
        chk("abort_reg", 80'(pack_dp()), 80'(pack_mdl()));

        // NOP with Run held high, then mv R2,R3 loaded straight after Done.
        Run = 1'b1;
        Din = 9'b110_000_000;
        tick();
        Din = 9'b000_010_011;
        #1;
        chk("nop_done", 80'(Done), 80'(1));
        chk("nop_bus",  80'(bus_sel), 80'(0));
        chk("nop_rin",  80'(Rin), 80'(0));
        tick();
        chk("nop_t0",   80'(step), 80'(0));
        chk("nop_irin", 80'(IRin), 80'(1));
        tick();
        Run = 1'b0;
        #1;
        chk("nop_next_ir",  80'(ir), 80'(9'b000_010_011));
        chk("nop_next_bus", 80'(bus_sel), 80'(10'b0001000000));
        tick();
        model_apply(9'b000_010_011, 9'h000);
        chk("nop_reg", 80'(pack_dp()), 80'(pack_mdl()));

        // Random instruction stream, including X==Y and NOP encodings.
        for (int k = 0; k < 60; k++)
            exec(9'($urandom), 9'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
